// File: rtl/sn_write_scheduler.sv
// sn_write_scheduler: round-robin byte-write arbiter feeding the SN76489 serial register path
//   CLK      system clock, everything on posedge
//   nRST     asynchronous active-low reset
//   REQ      per-requester level request, held until GNT
//   REQ_DATA byte of requester i at [8i+7:8i]
//   GNT      one-hot single-cycle accept pulse (combinational in IDLE)
//   SR_DATA  registered serial bit, LSB first, into the shift register MSB
//   LATCH    one-cycle strobe while the shift register holds the byte
//   LATCH_ID requester index of the latched byte
//   READY    high only while idle
module sn_write_scheduler #(
  parameter int N_REQ       = 2,
  parameter int BUSY_CYCLES = 32,
  localparam int IW         = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [N_REQ-1:0]     REQ,
  input  logic [8*N_REQ-1:0]   REQ_DATA,
  output logic [N_REQ-1:0]     GNT,
  output logic                 SR_DATA,
  output logic                 LATCH,
  output logic [IW-1:0]        LATCH_ID,
  output logic                 READY
);
  localparam int BW = BUSY_CYCLES > 1 ? $clog2(BUSY_CYCLES) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_BUSY} state_t;
  state_t state_q, state_d;
  logic [7:0] data_q, data_d, byte_sel;
  logic [IW-1:0] id_q, id_d, ptr_q, ptr_d, sel, idx;
  logic [2:0] bit_q, bit_d;
  logic [BW-1:0] busy_q, busy_d;
  logic sr_q, sr_d, any;
  // Scan downward so the requester closest after the pointer wins.
  always_comb begin
    sel = '0;
    idx = '0;
    any = 1'b0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = IW'((int'(ptr_q) + i) % N_REQ);
      if (REQ[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end
  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (sel == IW'(i)) byte_sel = REQ_DATA[8*i +: 8];
  end
  // data_q shifts right each SHIFT cycle, so data_q[1] is always the next bit;
  // after bit 7 it is zero, which leaves SR_DATA low in the LATCH cycle.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    sr_d    = 1'b0;
    GNT     = '0;
    LATCH   = 1'b0;
    READY   = 1'b0;
    case (state_q)
      S_IDLE: begin
        READY = 1'b1;
        if (any) begin
          GNT     = nRST ? N_REQ'(1) << sel : '0;
          data_d  = byte_sel;
          sr_d    = byte_sel[0];
          id_d    = sel;
          ptr_d   = sel;
          bit_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d  = data_q >> 1;
        sr_d    = data_q[1];
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? S_LATCH : S_SHIFT;
      end
      S_LATCH: begin
        LATCH   = 1'b1;
        busy_d  = BW'(BUSY_CYCLES - 1);
        state_d = BUSY_CYCLES == 0 ? S_IDLE : S_BUSY;
      end
      default: begin
        busy_d  = busy_q - 1'b1;
        state_d = busy_q == '0 ? S_IDLE : S_BUSY;
      end
    endcase
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      bit_q   <= '0;
      busy_q  <= '0;
      sr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      sr_q    <= sr_d;
    end
  assign SR_DATA  = sr_q;
  assign LATCH_ID = id_q;
endmodule

// File: tb/tb_sn_write_scheduler.sv
// tb_sn_write_scheduler: randomized and directed bench against a transaction-timing model
module tb_sn_write_scheduler;
  localparam int N = 2;
  localparam int B = 32;
  logic CLK = 1'b0, nRST = 1'b0;
  logic [1:0] REQ = '0;
  logic [15:0] REQ_DATA = '0;
  logic [1:0] GNT;
  logic SR_DATA, LATCH, LATCH_ID, READY;
  logic [1:0] req0 = '0;
  logic [15:0] dat0 = '0;
  logic [1:0] gnt0;
  logic sr0, lat0, lid0, rdy0;
  int errs = 0, checks = 0;
  always #5 CLK = ~CLK;
  sn_write_scheduler #(.N_REQ(N), .BUSY_CYCLES(B)) dut (
    .CLK(CLK), .nRST(nRST), .REQ(REQ), .REQ_DATA(REQ_DATA), .GNT(GNT),
    .SR_DATA(SR_DATA), .LATCH(LATCH), .LATCH_ID(LATCH_ID), .READY(READY));
  sn_write_scheduler #(.N_REQ(N), .BUSY_CYCLES(0)) dut0 (
    .CLK(CLK), .nRST(nRST), .REQ(req0), .REQ_DATA(dat0), .GNT(gnt0),
    .SR_DATA(sr0), .LATCH(lat0), .LATCH_ID(lid0), .READY(rdy0));
  // Chip-side shift registers: serial in at MSB, shift every clock, cleared by nRST.
  logic [7:0] shreg = '0, shr0 = '0;
  always @(posedge CLK or negedge nRST)
    if (!nRST) begin
      shreg <= '0;
      shr0  <= '0;
    end else begin
      shreg <= {SR_DATA, shreg[7:1]};
      shr0  <= {sr0, shr0[7:1]};
    end
  // Transaction model: a grant in cycle g means bits in g+1..g+8, LATCH at g+9,
  // next acceptance no earlier than g+10+B.
  int cyc_n = 0, g_c = -100, free_c = 0, last = N - 1, g_id = 0, exp_sel = 0;
  logic [7:0] g_byte = '0, exp_byte, exp_lbyte;
  logic [1:0] exp_gnt;
  logic exp_ready, exp_sr, exp_latch, exp_id, found;
  always @* begin
    exp_sel = 0;
    found = 1'b0;
    for (int k = 1; k <= N; k++)
      if (!found && REQ[(last + k) % N]) begin
        found = 1'b1;
        exp_sel = (last + k) % N;
      end
    exp_ready = cyc_n >= free_c;
    exp_gnt = (nRST && exp_ready && found) ? 2'(1 << exp_sel) : 2'b00;
    exp_byte = REQ_DATA[8*exp_sel +: 8];
    exp_sr = (cyc_n > g_c && cyc_n <= g_c + 8) ? g_byte[cyc_n - g_c - 1] : 1'b0;
    exp_latch = cyc_n == g_c + 9;
    exp_id = g_id[0];
    exp_lbyte = g_byte;
  end
  always @(posedge CLK or negedge nRST)
    if (!nRST) begin
      cyc_n  <= 0;
      g_c    <= -100;
      free_c <= 0;
      last   <= N - 1;
    end else begin
      cyc_n <= cyc_n + 1;
      if (|exp_gnt) begin
        g_c    <= cyc_n;
        g_byte <= exp_byte;
        g_id   <= exp_sel;
        last   <= exp_sel;
        free_c <= cyc_n + 10 + B;
      end
    end

  task automatic do_reset();
    @(posedge CLK); #1;
    nRST = 1'b0;
    REQ = '0;
    req0 = '0;
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    REQ = 2'b11;
    REQ_DATA = 16'h1234;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks += 6;
    if (GNT !== 2'b00) begin errs++; $display("FAIL reset gnt got=%b exp=00", GNT); end
    if (READY !== 1'b1) begin errs++; $display("FAIL reset ready got=%b exp=1", READY); end
    if (SR_DATA !== 1'b0) begin errs++; $display("FAIL reset sr_data got=%b exp=0", SR_DATA); end
    if (LATCH !== 1'b0) begin errs++; $display("FAIL reset latch got=%b exp=0", LATCH); end
    if (LATCH_ID !== 1'b0) begin errs++; $display("FAIL reset latch_id got=%b exp=0", LATCH_ID); end
    if (gnt0 !== 2'b00 || rdy0 !== 1'b1) begin errs++; $display("FAIL reset dut0 gnt=%b ready=%b exp 00/1", gnt0, rdy0); end
    @(posedge CLK); #1;
    REQ = '0;
    nRST = 1'b1;
  endtask

  task automatic test_single();
    int gc = -1, lc = -1, gn = 0;
    logic [7:0] seq = '0;
    do_reset();
    REQ = 2'b01;
    REQ_DATA = 16'h00A5;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      checks += 4;
      if (GNT !== exp_gnt) begin errs++; $display("FAIL single gnt c=%0d got=%b exp=%b", cyc_n, GNT, exp_gnt); end
      if (READY !== exp_ready) begin errs++; $display("FAIL single ready c=%0d got=%b exp=%b", cyc_n, READY, exp_ready); end
      if (SR_DATA !== exp_sr) begin errs++; $display("FAIL single sr_data c=%0d got=%b exp=%b", cyc_n, SR_DATA, exp_sr); end
      if (LATCH !== exp_latch) begin errs++; $display("FAIL single latch c=%0d got=%b exp=%b", cyc_n, LATCH, exp_latch); end
      if (GNT[0]) begin gn++; if (gc < 0) gc = c; end
      if (gc >= 0 && c > gc && c <= gc + 8) seq[c - gc - 1] = SR_DATA;
      if (LATCH) begin
        lc = c;
        checks += 2;
        if (shreg !== 8'hA5) begin errs++; $display("FAIL single shreg got=%h exp=a5", shreg); end
        if (LATCH_ID !== 1'b0) begin errs++; $display("FAIL single latch_id got=%b exp=0", LATCH_ID); end
      end
      @(posedge CLK); #1;
      if (gc >= 0) REQ = '0;
    end
    checks += 3;
    if (gn != 1) begin errs++; $display("FAIL single gnt_cycles got=%0d exp=1", gn); end
    if (gc < 0 || lc - gc != 9) begin errs++; $display("FAIL single latency got=%0d exp=9", lc - gc); end
    if (seq !== 8'hA5) begin errs++; $display("FAIL single bit_seq got=%h exp=a5", seq); end
  endtask

  task automatic test_fairness();
    int ids[$], lcs[$];
    logic [7:0] lbs[$];
    do_reset();
    REQ = 2'b11;
    REQ_DATA = 16'h9C12;
    for (int c = 0; c < 220; c++) begin
      @(negedge CLK);
      checks += 4;
      if (GNT !== exp_gnt) begin errs++; $display("FAIL fair gnt c=%0d got=%b exp=%b", cyc_n, GNT, exp_gnt); end
      if (READY !== exp_ready) begin errs++; $display("FAIL fair ready c=%0d got=%b exp=%b", cyc_n, READY, exp_ready); end
      if (SR_DATA !== exp_sr) begin errs++; $display("FAIL fair sr_data c=%0d got=%b exp=%b", cyc_n, SR_DATA, exp_sr); end
      if (LATCH !== exp_latch) begin errs++; $display("FAIL fair latch c=%0d got=%b exp=%b", cyc_n, LATCH, exp_latch); end
      if (|GNT) ids.push_back(GNT[1] ? 1 : 0);
      if (LATCH) begin lcs.push_back(c); lbs.push_back(shreg); end
      @(posedge CLK); #1;
      if (ids.size() >= 4) REQ = '0;
    end
    checks++;
    if (ids.size() != 4 || lcs.size() != 4) begin
      errs++; $display("FAIL fair counts grants=%0d latches=%0d exp=4/4", ids.size(), lcs.size());
    end else
      for (int k = 0; k < 4; k++) begin
        checks += 2;
        if (ids[k] != k % 2) begin errs++; $display("FAIL fair order k=%0d got=%0d exp=%0d", k, ids[k], k % 2); end
        if (lbs[k] !== (k % 2 ? 8'h9C : 8'h12)) begin errs++; $display("FAIL fair byte k=%0d got=%h", k, lbs[k]); end
        if (k > 0) begin
          checks++;
          if (lcs[k] - lcs[k-1] != 42) begin errs++; $display("FAIL fair spacing k=%0d got=%0d exp=42", k, lcs[k] - lcs[k-1]); end
        end
      end
  endtask

  task automatic test_busy_pending();
    int lc = -1, g1 = -1, busy_lo = 0;
    do_reset();
    REQ = 2'b01;
    REQ_DATA = 16'h773C;
    for (int c = 0; c < 80; c++) begin
      @(negedge CLK);
      checks += 4;
      if (GNT !== exp_gnt) begin errs++; $display("FAIL busy gnt c=%0d got=%b exp=%b", cyc_n, GNT, exp_gnt); end
      if (READY !== exp_ready) begin errs++; $display("FAIL busy ready c=%0d got=%b exp=%b", cyc_n, READY, exp_ready); end
      if (SR_DATA !== exp_sr) begin errs++; $display("FAIL busy sr_data c=%0d got=%b exp=%b", cyc_n, SR_DATA, exp_sr); end
      if (LATCH !== exp_latch) begin errs++; $display("FAIL busy latch c=%0d got=%b exp=%b", cyc_n, LATCH, exp_latch); end
      if (lc >= 0 && c > lc && g1 < 0 && READY === 1'b0) busy_lo++;
      if (GNT[1] && g1 < 0) g1 = c;
      if (LATCH && lc < 0) lc = c;
      @(posedge CLK); #1;
      if (c == 0) REQ[0] = 1'b0;
      if (lc == c) REQ[1] = 1'b1;
      if (g1 >= 0) REQ[1] = 1'b0;
    end
    checks += 2;
    if (lc < 0 || g1 - lc != 33) begin errs++; $display("FAIL busy grant_delay got=%0d exp=33", g1 - lc); end
    if (busy_lo != 32) begin errs++; $display("FAIL busy ready_low got=%0d exp=32", busy_lo); end
  endtask

  task automatic test_withdraw();
    int g1n = 0, l1n = 0;
    do_reset();
    REQ = 2'b01;
    REQ_DATA = 16'h5501;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      checks += 4;
      if (GNT !== exp_gnt) begin errs++; $display("FAIL withdraw gnt c=%0d got=%b exp=%b", cyc_n, GNT, exp_gnt); end
      if (READY !== exp_ready) begin errs++; $display("FAIL withdraw ready c=%0d got=%b exp=%b", cyc_n, READY, exp_ready); end
      if (SR_DATA !== exp_sr) begin errs++; $display("FAIL withdraw sr_data c=%0d got=%b exp=%b", cyc_n, SR_DATA, exp_sr); end
      if (LATCH !== exp_latch) begin errs++; $display("FAIL withdraw latch c=%0d got=%b exp=%b", cyc_n, LATCH, exp_latch); end
      if (GNT[1]) g1n++;
      if (LATCH && LATCH_ID) l1n++;
      @(posedge CLK); #1;
      if (c == 0) REQ[0] = 1'b0;
      if (c == 15) REQ[1] = 1'b1;
      if (c == 30) REQ[1] = 1'b0;
    end
    checks += 2;
    if (g1n != 0) begin errs++; $display("FAIL withdraw gnt1 got=%0d exp=0", g1n); end
    if (l1n != 0) begin errs++; $display("FAIL withdraw latch1 got=%0d exp=0", l1n); end
  endtask

  task automatic test_reset_mid();
    int ln = 0;
    logic [7:0] lb = '0;
    do_reset();
    REQ = 2'b01;
    REQ_DATA = 16'h00F0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      checks += 2;
      if (GNT !== exp_gnt) begin errs++; $display("FAIL rstmid gnt c=%0d got=%b exp=%b", cyc_n, GNT, exp_gnt); end
      if (SR_DATA !== exp_sr) begin errs++; $display("FAIL rstmid sr_data c=%0d got=%b exp=%b", cyc_n, SR_DATA, exp_sr); end
      @(posedge CLK); #1;
      REQ = '0;
    end
    #2 nRST = 1'b0;
    #1;
    checks += 4;
    if (SR_DATA !== 1'b0) begin errs++; $display("FAIL rstmid async_sr got=%b exp=0", SR_DATA); end
    if (READY !== 1'b1) begin errs++; $display("FAIL rstmid async_ready got=%b exp=1", READY); end
    if (LATCH !== 1'b0 || GNT !== 2'b00) begin errs++; $display("FAIL rstmid async_latch_gnt got=%b/%b exp=0/00", LATCH, GNT); end
    if (LATCH_ID !== 1'b0) begin errs++; $display("FAIL rstmid async_id got=%b exp=0", LATCH_ID); end
    @(posedge CLK); #1;
    nRST = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge CLK);
      checks += 4;
      if (GNT !== exp_gnt) begin errs++; $display("FAIL rstmid gnt c=%0d got=%b exp=%b", cyc_n, GNT, exp_gnt); end
      if (READY !== exp_ready) begin errs++; $display("FAIL rstmid ready c=%0d got=%b exp=%b", cyc_n, READY, exp_ready); end
      if (SR_DATA !== exp_sr) begin errs++; $display("FAIL rstmid sr_data c=%0d got=%b exp=%b", cyc_n, SR_DATA, exp_sr); end
      if (LATCH !== exp_latch) begin errs++; $display("FAIL rstmid latch c=%0d got=%b exp=%b", cyc_n, LATCH, exp_latch); end
      if (LATCH && c < 30) ln++;
      if (LATCH && c >= 30) lb = shreg;
      @(posedge CLK); #1;
      if (c == 29) begin REQ = 2'b01; REQ_DATA = 16'h005A; end
      if (c == 30) REQ = '0;
    end
    checks += 2;
    if (ln != 0) begin errs++; $display("FAIL rstmid stray_latch got=%0d exp=0", ln); end
    if (lb !== 8'h5A) begin errs++; $display("FAIL rstmid next_byte got=%h exp=5a", lb); end
  endtask

  task automatic test_random();
    logic [1:0] gs;
    do_reset();
    for (int c = 0; c < 900; c++) begin
      @(negedge CLK);
      checks += 4;
      if (GNT !== exp_gnt) begin errs++; $display("FAIL random gnt c=%0d got=%b exp=%b", cyc_n, GNT, exp_gnt); end
      if (READY !== exp_ready) begin errs++; $display("FAIL random ready c=%0d got=%b exp=%b", cyc_n, READY, exp_ready); end
      if (SR_DATA !== exp_sr) begin errs++; $display("FAIL random sr_data c=%0d got=%b exp=%b", cyc_n, SR_DATA, exp_sr); end
      if (LATCH !== exp_latch) begin errs++; $display("FAIL random latch c=%0d got=%b exp=%b", cyc_n, LATCH, exp_latch); end
      if (exp_latch) begin
        checks++;
        if ({LATCH_ID, shreg} !== {exp_id, exp_lbyte}) begin
          errs++; $display("FAIL random latch_data c=%0d got=%b/%h exp=%b/%h", cyc_n, LATCH_ID, shreg, exp_id, exp_lbyte);
        end
      end
      gs = GNT;
      @(posedge CLK); #1;
      for (int i = 0; i < N; i++)
        if (gs[i] || !REQ[i]) begin
          REQ[i] = gs[i] ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
          REQ_DATA[8*i +: 8] = 8'($urandom);
        end else if ($urandom_range(0, 19) == 0)
          REQ[i] = 1'b0;
    end
    REQ = '0;
  endtask

  task automatic test_no_busy();
    int g[$], l[$];
    logic [7:0] b[$];
    int both = 0;
    do_reset();
    req0 = 2'b01;
    dat0 = 16'h00FF;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (gnt0[0]) g.push_back(c);
      if (lat0) begin l.push_back(c); b.push_back(shr0); end
      if (lat0 && |gnt0) both++;
      @(posedge CLK); #1;
      if (g.size() == 1) dat0 = 16'h0000;
      if (g.size() >= 2) req0 = '0;
    end
    checks += 2;
    if (both != 0) begin errs++; $display("FAIL nobusy gnt_with_latch got=%0d exp=0", both); end
    if (g.size() != 2 || l.size() != 2) begin
      errs++; $display("FAIL nobusy counts grants=%0d latches=%0d exp=2/2", g.size(), l.size());
    end else begin
      checks += 4;
      if (l[0] - g[0] != 9) begin errs++; $display("FAIL nobusy latency got=%0d exp=9", l[0] - g[0]); end
      if (l[1] - l[0] != 10) begin errs++; $display("FAIL nobusy spacing got=%0d exp=10", l[1] - l[0]); end
      if (b[0] !== 8'hFF) begin errs++; $display("FAIL nobusy byte0 got=%h exp=ff", b[0]); end
      if (b[1] !== 8'h00) begin errs++; $display("FAIL nobusy byte1 got=%h exp=00", b[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_busy_pending();
    test_withdraw();
    test_reset_mid();
    test_random();
    test_no_busy();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
